// File: rtl/bimodal_pkg.sv
// Shared definitions for the bimodal counter table and the tagged tables that reuse its pieces.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
// Contents: FSM state enum, default index/counter widths, default clear value helper.
package bimodal_pkg;

  // Table sequencer states: CLEAR sweeps INIT_VAL into every entry, RUN serves traffic.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int IL_DEF = 13;
  localparam int CL_DEF = 3;

  // Weakly not-taken: the largest value whose MSB is still 0.
  function automatic int unsigned init_val_default(input int cl);
    return (32'd1 << (cl - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bimodal_ctr_table_if.sv
// Bundles the request/response signals of the bimodal counter table.
// Latency: n/a (wiring only).
// Backpressure: requester must hold off reads/updates while ready is low; they are ignored then.
// Ports: flush, rd_en/rd_index, upd_en/upd_index/upd_taken (requester -> table);
//        ready, rd_valid, rd_ctr, rd_pred (table -> requester).
interface bimodal_ctr_table_if
  import bimodal_pkg::*;
#(
  parameter int IL = IL_DEF,
  parameter int CL = CL_DEF
);

  logic          flush;
  logic          ready;
  logic          rd_en;
  logic [IL-1:0] rd_index;
  logic          rd_valid;
  logic [CL-1:0] rd_ctr;
  logic          rd_pred;
  logic          upd_en;
  logic [IL-1:0] upd_index;
  logic          upd_taken;

  modport master (
    output flush, rd_en, rd_index, upd_en, upd_index, upd_taken,
    input  ready, rd_valid, rd_ctr, rd_pred
  );

  modport slave (
    input  flush, rd_en, rd_index, upd_en, upd_index, upd_taken,
    output ready, rd_valid, rd_ctr, rd_pred
  );

endinterface

// File: rtl/sat_ctr_next.sv
// Saturating up/down step for a CL-bit prediction counter.
// Latency: combinational.
// Backpressure: none.
// Ports: ctr (current value), dir (1: count up, 0: count down), nxt (saturated next value).
module sat_ctr_next #(
  parameter int CL = 3
) (
  input  logic [CL-1:0] ctr,
  input  logic          dir,
  output logic [CL-1:0] nxt
);

  localparam logic [CL-1:0] ONE = CL'(1);
  localparam logic [CL-1:0] MAX = {CL{1'b1}};

  always_comb begin
    nxt = ctr;
    if (dir) begin
      if (ctr != MAX) nxt = ctr + ONE;
    end else begin
      if (ctr != '0) nxt = ctr - ONE;
    end
  end

endmodule

// File: rtl/bimodal_ctr_table.sv
// Base (untagged) bimodal saturating-counter table with hardware clear sweep and read/update bypass.
// Latency: reads return 1 cycle after rd_en; updates visible to the next cycle's read (same cycle via bypass).
// Backpressure: ready=0 for 2^IL cycles after reset or flush; rd_en/upd_en are dropped while ready=0.
// Ports: Clk, Rst_n (async active-low); bus (slave side of bimodal_ctr_table_if).
module bimodal_ctr_table
  import bimodal_pkg::*;
#(
  parameter int          IL       = IL_DEF,
  parameter int          CL       = CL_DEF,
  parameter int unsigned INIT_VAL = init_val_default(CL)
) (
  input logic                Clk,
  input logic                Rst_n,
  bimodal_ctr_table_if.slave bus
);

  localparam int            DEPTH    = 1 << IL;
  localparam logic [0:0]    ST_CLEAR = CLEAR;
  localparam logic [0:0]    ST_RUN   = RUN;
  // Pointer carries one extra bit so the terminal count is an explicit compare.
  localparam logic [IL:0]   LAST_PTR = (IL + 1)'(DEPTH - 1);
  localparam logic [IL:0]   PTR_ONE  = (IL + 1)'(1);
  localparam logic [CL-1:0] INIT_CTR = CL'(INIT_VAL);

  logic [CL-1:0] mem [DEPTH];

  logic [0:0]    state_q;
  logic [IL:0]   ptr_q;
  logic          ready_q;
  logic          rd_valid_q;
  logic [CL-1:0] rd_ctr_q;

  logic          run_go;
  logic          do_rd;
  logic          do_upd;
  logic          rd_byp;
  logic [CL-1:0] upd_cur;
  logic [CL-1:0] upd_nxt;
  logic [CL-1:0] rd_src;

  logic          we;
  logic [IL-1:0] waddr;
  logic [CL-1:0] wdata;

  // A flush cycle drops whatever read/update arrives alongside it.
  assign run_go = (state_q == ST_RUN) && !bus.flush;
  assign do_rd  = run_go && bus.rd_en;
  assign do_upd = run_go && bus.upd_en;
  assign rd_byp = do_upd && (bus.upd_index == bus.rd_index);

  assign upd_cur = mem[bus.upd_index];

  sat_ctr_next #(.CL(CL)) u_sat (
    .ctr (upd_cur),
    .dir (bus.upd_taken),
    .nxt (upd_nxt)
  );

  // Same-index read/update returns the post-update value.
  assign rd_src = rd_byp ? upd_nxt : mem[bus.rd_index];

  // Single write port: sweep owns it in CLEAR, updates own it in RUN.
  always_comb begin
    we    = 1'b0;
    waddr = bus.upd_index;
    wdata = upd_nxt;
    if (state_q == ST_CLEAR) begin
      we    = !bus.flush;
      waddr = ptr_q[IL-1:0];
      wdata = INIT_CTR;
    end else begin
      we = do_upd;
    end
  end

  // Storage is deliberately not reset; the sweep initialises it.
  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_CLEAR;
      ptr_q      <= '0;
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_ctr_q   <= '0;
    end else begin
      rd_valid_q <= do_rd;
      if (do_rd) rd_ctr_q <= rd_src;

      if (bus.flush) begin
        state_q <= ST_CLEAR;
        ptr_q   <= '0;
        ready_q <= 1'b0;
      end else if (state_q == ST_CLEAR) begin
        if (ptr_q == LAST_PTR) begin
          // Same edge that writes the last entry opens the table.
          state_q <= ST_RUN;
          ptr_q   <= '0;
          ready_q <= 1'b1;
        end else begin
          ptr_q <= ptr_q + PTR_ONE;
        end
      end
    end
  end

  assign bus.ready    = ready_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_ctr   = rd_ctr_q;
  assign bus.rd_pred  = rd_ctr_q[CL-1];

endmodule

// File: tb/tb_bimodal_ctr_table.sv
// Scoreboard bench for bimodal_ctr_table (IL=4, CL=3, INIT_VAL=3).
// Latency: expects rd_valid exactly one cycle after each accepted rd_en.
// Backpressure: checks ready stays low for 16 cycles after reset/flush and that requests are ignored then.
module tb_bimodal_ctr_table;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [2:0] ctr;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  bimodal_ctr_table_if #(.IL(4), .CL(3)) bus ();

  bimodal_ctr_table #(.IL(4), .CL(3)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, expv, cyc);
    end
  endtask

  task automatic clr_inputs();
    bus.flush     = 1'b0;
    bus.rd_en     = 1'b0;
    bus.rd_index  = '0;
    bus.upd_en    = 1'b0;
    bus.upd_index = '0;
    bus.upd_taken = 1'b0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One stimulus cycle; an accepted read pushes its hand-computed result.
  task automatic drive(input logic re, input int ri, input logic [2:0] rexp,
                       input logic ue, input int ui, input logic tk, input logic fl);
    bus.rd_en     = re;
    bus.rd_index  = 4'(ri);
    bus.upd_en    = ue;
    bus.upd_index = 4'(ui);
    bus.upd_taken = tk;
    bus.flush     = fl;
    if (re && !fl) exp_q.push_back('{ctr: rexp, cyc: cyc + 1});
    step();
    clr_inputs();
  endtask

  // 16 sweep cycles with junk requests that must be ignored, then ready must rise.
  task automatic sweep_check(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_ready_low"}, bus.ready, 0);
      chk({tag, "_no_rd_valid"}, bus.rd_valid, 0);
      bus.rd_en     = 1'b1;
      bus.rd_index  = 4'(i);
      bus.upd_en    = 1'b1;
      bus.upd_index = 4'(i);
      bus.upd_taken = 1'b1;
      step();
    end
    clr_inputs();
    chk({tag, "_ready_high"}, bus.ready, 1);
  endtask

  always @(negedge Clk) begin : monitor
    exp_t e;
    if (Rst_n === 1'b1 && bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_valid_unexpected actual=1 required=0 rd_ctr=%0d cycle=%0d", bus.rd_ctr, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("rd_ctr", bus.rd_ctr, e.ctr);
        chk("rd_pred", bus.rd_pred, e.ctr[2]);
        chk("rd_latency", cyc, e.cyc);
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog actual=timeout required=finish cycle=%0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin : stim
    clr_inputs();
    #2 Rst_n = 1'b0;
    #1;
    chk("rst_ready", bus.ready, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_ctr", bus.rd_ctr, 0);
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;

    // Boot sweep and full-table readback.
    sweep_check("boot");
    for (int i = 0; i < 16; i++) drive(1, i, 3'd3, 0, 0, 0, 0);

    // Saturation at the top and bottom of entry 5.
    repeat (6) drive(0, 0, 0, 1, 5, 1, 0);
    drive(1, 5, 3'd7, 0, 0, 0, 0);
    repeat (9) drive(0, 0, 0, 1, 5, 0, 0);
    drive(1, 5, 3'd0, 0, 0, 0, 0);

    // Bypass on same index, independence on different indices.
    drive(1, 2, 3'd4, 1, 2, 1, 0);
    drive(1, 2, 3'd4, 1, 9, 1, 0);
    drive(1, 9, 3'd4, 0, 0, 0, 0);
    drive(1, 9, 3'd3, 1, 9, 0, 0);

    // Idle read holds the last value.
    drive(0, 0, 0, 1, 5, 1, 0);
    drive(1, 5, 3'd1, 0, 0, 0, 0);
    step();
    chk("idle_rd_valid", bus.rd_valid, 0);
    chk("idle_rd_ctr_hold", bus.rd_ctr, 1);
    chk("idle_rd_ctr_known", 32'($isunknown(bus.rd_ctr)), 0);
    step();
    chk("idle2_rd_valid", bus.rd_valid, 0);
    chk("idle2_rd_ctr_hold", bus.rd_ctr, 1);

    // Flush mid-run with a concurrent update and read that must be dropped.
    repeat (3) drive(0, 0, 0, 1, 7, 1, 0);
    drive(1, 7, 3'd6, 0, 0, 0, 0);
    drive(1, 7, 3'd0, 1, 7, 1, 1);
    sweep_check("flush");
    drive(1, 7, 3'd3, 0, 0, 0, 0);
    drive(1, 5, 3'd3, 0, 0, 0, 0);

    // Reset asserted part-way through a sweep.
    repeat (2) drive(0, 0, 0, 1, 12, 1, 0);
    drive(1, 12, 3'd5, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    repeat (8) step();
    Rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", bus.ready, 0);
    chk("mid_rst_rd_valid", bus.rd_valid, 0);
    chk("mid_rst_rd_ctr", bus.rd_ctr, 0);
    chk("mid_rst_rd_pred", bus.rd_pred, 0);
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
    sweep_check("rst_mid");
    drive(1, 12, 3'd3, 0, 0, 0, 0);
    drive(1, 0, 3'd3, 0, 0, 0, 0);

    repeat (3) step();
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bimodal_ctr_table.md
# bimodal_ctr_table

Parametrised saturating-counter prediction table, the successor to the fixed bimodal table. It has decoupled read and update indices, a registered read with a valid strobe, read/update bypass, and a hardware clear sweep. The clear sweep runs after reset and on flush, so the array is initialised by hardware and not by simulation-only initial blocks. It sits in the predictor front end as the base (untagged) component that supplies the default prediction to the tagged tables.

## Interface
- IL, 13, index width; table depth is 2^IL entries
- CL, 3, counter width in bits (CL ≥ 2)
- INIT_VAL, 2^(CL-1)-1, value written by the clear sweep (weakly not-taken)
- Clk  in  1  clock, all logic on posedge
- Rst_n  in  1  asynchronous active-low reset
- flush  in  1  request a full-table clear to INIT_VAL
- ready  out  1  table accepting reads/updates
- rd_en  in  1  read request
- rd_index  in  IL  read address
- rd_valid  out  1  rd_ctr/rd_pred valid this cycle
- rd_ctr  out  CL  counter value read
- rd_pred  out  1  prediction = MSB of rd_ctr
- upd_en  in  1  update request
- upd_index  in  IL  update address
- upd_taken  in  1  1: increment, 0: decrement

## Operation
- FSM states: CLEAR, RUN.
- Reset (Rst_n=0): state=CLEAR, sweep pointer=0, ready=0, rd_valid=0, rd_ctr=0, rd_pred=0. Array contents are not reset.
- CLEAR: each cycle writes INIT_VAL to entry[ptr], then ptr+1. When the write to entry 2^IL-1 completes, the FSM moves to RUN. ready=0 throughout. rd_en and upd_en are ignored; rd_valid stays 0.
- RUN: ready=1.
  - Update: when upd_en=1, entry[upd_index] gets the saturating increment (upd_taken=1) or decrement (upd_taken=0).
  - Saturation: an increment at all-ones is held; a decrement at 0 is held. No wrap-around.
  - Read: when rd_en=1, rd_ctr is registered from entry[rd_index] and rd_valid=1 on the next cycle. When rd_en=0, rd_valid=0 next cycle and rd_ctr/rd_pred hold their last value (no X output).
  - Bypass: if rd_en and upd_en are both 1 with rd_index==upd_index, rd_ctr returns the post-update value.
  - Different indices in the same cycle: read and update are independent.
- flush=1 in RUN: next state is CLEAR with ptr=0. A read or update in the flush cycle is dropped; rd_valid=0 next cycle.
- flush=1 in CLEAR: ptr restarts at 0.
- Reset asserted mid-sweep: the sweep restarts from 0 after reset deasserts.
- Arithmetic is CL bits unsigned. The ptr is IL+1 bits wide so that terminal count is detectable.

## Timing
- Read latency: 1 cycle (request at edge n, data and rd_valid after edge n+1).
- Update is visible to reads issued on the following cycle. Same-cycle reads see it via the bypass.
- Clear duration: exactly 2^IL cycles from the first CLEAR edge. ready rises on the edge that writes the last entry.
- Throughput: one read plus one update per cycle in RUN.
- ready, rd_valid, rd_ctr and rd_pred are registered outputs. No combinational path from inputs to outputs.

## Structure
- Package bimodal_pkg holds:
  - the state enum (CLEAR, RUN)
  - the default IL/CL constants
  - a function for the INIT_VAL default
- Sub-module sat_ctr_next (combinational): inputs ctr[CL] and dir; output is the saturated next value. It is reused by the tagged tables.
- The array is a single storage memory with one write port (sweep or update, muxed by state) and one read port. It must be inferable as RAM except for the bypass mux.

## Test plan
- Reset, IL=4, CL=3. Check ready=0 for 16 cycles, then ready=1. Then read all 16 entries: each must give rd_ctr=3, rd_pred=0, rd_valid=1 exactly one cycle after each rd_en.
- Saturation: 6 consecutive upd_taken=1 to index 5, then read → rd_ctr=7. Then 9 decrements, then read → rd_ctr=0.
- Bypass: entry 2=3. In one cycle, upd_en taken to index 2 plus rd_en index 2 → next cycle rd_ctr=4, rd_pred=1. In a separate cycle, a read of index 2 plus an update of index 9 returns the old value with no interference.
- Flush mid-run: set entry 7=6, assert flush with a concurrent update. Check ready=0 for 16 cycles, no rd_valid, and entry 7 reads 3 afterwards.
- Reset mid-sweep: assert Rst_n=0 at sweep cycle 8 for 2 cycles. Outputs must be at reset values immediately (asynchronous), and ready must rise exactly 16 cycles after deassertion.
- Idle read: rd_en=0 after a valid read. Check rd_valid=0 and rd_ctr holds its previous value, never X.
